// File: rtl/bayer2rgb_param.sv
// Bayer 2x2 block merger: even rows are buffered in a line RAM, odd rows read it back
// and each complete 2x2 block becomes one RGB pixel two cycles after its bottom-right sample.
module bayer2rgb_param #(
    parameter int DATA_W   = 12,
    parameter int CNT_W    = 11,
    parameter int LINE_MAX = 2048
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [CNT_W-1:0]  iX_Cont,
    input  logic [CNT_W-1:0]  iY_Cont,
    input  logic [1:0]        iPATTERN,
    input  logic [1:0]        iGREEN_MODE,
    input  logic              iOVF_CLR,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL,
    output logic              oOVF
);

    localparam int             AW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam logic [CNT_W:0] LINE_LIM = (CNT_W+1)'(LINE_MAX);
    localparam logic [CNT_W:0] CNT_ONE  = 1;

    logic [DATA_W-1:0] mem [0:LINE_MAX-1];
    logic [DATA_W-1:0] ram_q;

    logic [CNT_W:0]    x_ext;
    logic              in_range;
    logic              even_px;
    logic              odd_px;
    logic              frame_start;
    logic [AW-1:0]     addr;

    logic [CNT_W:0]    stored_cnt;
    logic [1:0]        pat_q;
    logic [1:0]        mode_q;
    logic              bl_ok;
    logic [DATA_W-1:0] bl_q;

    logic              s1_v;
    logic [DATA_W-1:0] s1_tl;
    logic [DATA_W-1:0] s1_bl;
    logic [DATA_W-1:0] s1_br;
    logic [1:0]        s1_pat;
    logic [1:0]        s1_mode;

    logic              s2_v;
    logic [DATA_W-1:0] s2_r;
    logic [DATA_W-1:0] s2_g;
    logic [DATA_W-1:0] s2_b;

    logic [DATA_W-1:0] r_c;
    logic [DATA_W-1:0] g_c;
    logic [DATA_W-1:0] b_c;
    logic [DATA_W-1:0] g1_c;
    logic [DATA_W-1:0] g2_c;
    logic [DATA_W:0]   gsum_c;

    assign x_ext       = {1'b0, iX_Cont};
    assign in_range    = (x_ext < LINE_LIM);
    assign even_px     = iDVAL & ~iY_Cont[0];
    assign odd_px      = iDVAL & iY_Cont[0];
    assign frame_start = iDVAL && (iX_Cont == '0) && (iY_Cont == '0);
    assign addr        = iX_Cont[AW-1:0];

    // Line RAM is never reset; stored_cnt gates any use of stale contents.
    always_ff @(posedge iCLK) begin
        if (even_px && in_range)
            mem[addr] <= iDATA;
        if (odd_px)
            ram_q <= mem[addr];
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            stored_cnt <= '0;
            pat_q      <= 2'b10;
            mode_q     <= 2'b00;
            oOVF       <= 1'b0;
            bl_ok      <= 1'b0;
            bl_q       <= '0;
            s1_v       <= 1'b0;
            s1_tl      <= '0;
            s1_bl      <= '0;
            s1_br      <= '0;
            s1_pat     <= 2'b10;
            s1_mode    <= 2'b00;
            s2_v       <= 1'b0;
            s2_r       <= '0;
            s2_g       <= '0;
            s2_b       <= '0;
            oDVAL      <= 1'b0;
            oRed       <= '0;
            oGreen     <= '0;
            oBlue      <= '0;
        end else begin
            if (frame_start) begin
                pat_q  <= iPATTERN;
                mode_q <= iGREEN_MODE;
            end
            if (even_px && in_range)
                stored_cnt <= x_ext + CNT_ONE;
            if (even_px && !in_range)
                oOVF <= 1'b1;
            else if (iOVF_CLR)
                oOVF <= 1'b0;

            // ram_q still holds the top-left sample read alongside the bottom-left one.
            if (odd_px && !iX_Cont[0]) begin
                bl_ok <= 1'b1;
                bl_q  <= iDATA;
            end else if (iDVAL) begin
                bl_ok <= 1'b0;
            end

            s1_v <= odd_px && iX_Cont[0] && bl_ok && (x_ext < stored_cnt);
            if (odd_px && iX_Cont[0]) begin
                s1_tl   <= ram_q;
                s1_bl   <= bl_q;
                s1_br   <= iDATA;
                s1_pat  <= pat_q;
                s1_mode <= mode_q;
            end

            s2_v <= s1_v;
            if (s1_v) begin
                s2_r <= r_c;
                s2_g <= g_c;
                s2_b <= b_c;
            end

            oDVAL <= s2_v;
            if (s2_v) begin
                oRed   <= s2_r;
                oGreen <= s2_g;
                oBlue  <= s2_b;
            end
        end
    end

    // ram_q carries the top-right sample during the cycle after the bottom-right accept.
    always_comb begin
        r_c  = '0;
        b_c  = '0;
        g1_c = '0;
        g2_c = '0;
        g_c  = '0;
        case (s1_pat)
            2'b00: begin g1_c = s1_tl; r_c  = ram_q; b_c  = s1_bl; g2_c = s1_br; end
            2'b01: begin r_c  = s1_tl; g1_c = ram_q; g2_c = s1_bl; b_c  = s1_br; end
            2'b10: begin b_c  = s1_tl; g1_c = ram_q; g2_c = s1_bl; r_c  = s1_br; end
            default: begin g1_c = s1_tl; b_c = ram_q; r_c = s1_bl; g2_c = s1_br; end
        endcase
        gsum_c = {1'b0, g1_c} + {1'b0, g2_c};
        case (s1_mode)
            2'b00:   g_c = gsum_c[DATA_W:1];
            2'b01:   g_c = g1_c;
            2'b10:   g_c = g2_c;
            default: g_c = (g1_c > g2_c) ? g1_c : g2_c;
        endcase
    end

endmodule

// File: tb/tb_bayer2rgb_param.sv
// Directed bench for bayer2rgb_param: a reference model pushes expected RGB blocks
// with their due cycle, a negedge monitor pops and checks them every cycle.
module tb_bayer2rgb_param;

    localparam int DW = 12;
    localparam int CW = 11;
    localparam int LM = 8;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic [DW-1:0] data = '0;
    logic          dval = 1'b0;
    logic [CW-1:0] xc = '0;
    logic [CW-1:0] yc = '0;
    logic [1:0]    pattern = 2'b10;
    logic [1:0]    gmode = 2'b00;
    logic          ovf_clr = 1'b0;
    logic [DW-1:0] red, green, blue;
    logic          out_dval, ovf;

    typedef struct {
        int cyc;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t q[$];
    exp_t me;
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int line_m[LM];
    int stored_m = 0;
    int pat_m = 2;
    int mode_m = 0;
    int bl_ok = 0;
    int bl_v = 0;
    int tl_v = 0;
    int last_r = 0;
    int last_g = 0;
    int last_b = 0;

    bayer2rgb_param #(.DATA_W(DW), .CNT_W(CW), .LINE_MAX(LM)) dut (
        .iCLK(clk), .iRST(rst_b), .iDATA(data), .iDVAL(dval),
        .iX_Cont(xc), .iY_Cont(yc), .iPATTERN(pattern), .iGREEN_MODE(gmode),
        .iOVF_CLR(ovf_clr), .oRed(red), .oGreen(green), .oBlue(blue),
        .oDVAL(out_dval), .oOVF(ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input int tl, input int tr, input int bl, input int br);
        int r, g, b, g1, g2;
        r = 0; g = 0; b = 0; g1 = 0; g2 = 0;
        case (pat_m)
            0: begin g1 = tl; r = tr; b = bl; g2 = br; end
            1: begin r = tl; g1 = tr; g2 = bl; b = br; end
            2: begin b = tl; g1 = tr; g2 = bl; r = br; end
            default: begin g1 = tl; b = tr; r = bl; g2 = br; end
        endcase
        case (mode_m)
            0: g = (g1 + g2) / 2;
            1: g = g1;
            2: g = g2;
            default: g = (g1 > g2) ? g1 : g2;
        endcase
        q.push_back('{cyc + 3, r, g, b});
    endtask

    task automatic pix(input int x, input int y, input int d);
        @(negedge clk);
        xc = CW'(x); yc = CW'(y); data = DW'(d); dval = 1'b1; ovf_clr = 1'b0;
        if (x == 0 && y == 0) begin pat_m = int'(pattern); mode_m = int'(gmode); end
        if (y % 2 == 0) begin
            bl_ok = 0;
            if (x < LM) begin line_m[x] = d; stored_m = x + 1; end
        end else if (x % 2 == 0) begin
            bl_ok = 1; bl_v = d; tl_v = line_m[x % LM];
        end else begin
            if (bl_ok != 0 && x < stored_m) push(tl_v, line_m[x % LM], bl_v, d);
            bl_ok = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            dval = 1'b0; ovf_clr = 1'b0;
        end
    endtask

    task automatic row4(input int y, input int a, input int b, input int c, input int d);
        pix(0, y, a); pix(1, y, b); pix(2, y, c); pix(3, y, d);
    endtask

    always @(negedge clk) begin
        if (!rst_b) begin
            last_r = 0; last_g = 0; last_b = 0;
            check("rst_red", red, 0);
            check("rst_green", green, 0);
            check("rst_blue", blue, 0);
            check("rst_dval", out_dval, 0);
            check("rst_ovf", ovf, 0);
        end else if (q.size() > 0 && q[0].cyc == cyc) begin
            me = q.pop_front();
            check("dval_due", out_dval, 1);
            check("red", red, me.r);
            check("green", green, me.g);
            check("blue", blue, me.b);
            last_r = me.r; last_g = me.g; last_b = me.b;
        end else begin
            check("no_dval", out_dval, 0);
            check("hold_red", red, last_r);
            check("hold_green", green, last_g);
            check("hold_blue", blue, last_b);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        @(negedge clk) rst_b = 1'b1;
        idle(2);
        check("ovf_after_reset", ovf, 0);

        // BGGR average: expect (400,250,100) and (410,260,110)
        pattern = 2'b10; gmode = 2'b00;
        row4(0, 100, 200, 110, 210);
        row4(1, 300, 400, 310, 410);
        idle(4);

        // GRBG max: expect (200,400,300) and (210,410,310)
        pattern = 2'b00; gmode = 2'b11;
        row4(0, 100, 200, 110, 210);
        row4(1, 300, 400, 310, 410);
        idle(4);

        // full-scale greens, average must not wrap
        pattern = 2'b00; gmode = 2'b00;
        row4(0, 4095, 200, 4095, 17);
        row4(1, 300, 4095, 1, 4095);
        idle(4);

        // RGGB G1-only with gaps between samples
        pattern = 2'b01; gmode = 2'b01;
        pix(0, 0, 11); idle(2); pix(1, 0, 22); pix(2, 0, 33); idle(1); pix(3, 0, 44);
        pix(0, 1, 55); idle(3); pix(1, 1, 66); idle(1); pix(2, 1, 77); idle(2); pix(3, 1, 88);
        idle(4);

        // GBRG G2-only, then mid-frame pattern change ignored; frames back to back
        pattern = 2'b11; gmode = 2'b10;
        row4(0, 1000, 1100, 1200, 1300);
        row4(1, 1400, 1500, 1600, 1700);
        pattern = 2'b01; gmode = 2'b11;
        row4(0, 5, 6, 7, 8);
        pattern = 2'b00; gmode = 2'b00;
        row4(1, 9, 10, 11, 12);
        pattern = 2'b10; gmode = 2'b00;
        row4(0, 21, 22, 23, 24);
        row4(1, 25, 26, 27, 28);
        idle(4);

        // overflow at col LM, blocks beyond stored count suppressed
        pattern = 2'b10; gmode = 2'b00;
        for (int x = 0; x < 8; x++) pix(x, 0, 10 * x + 1);
        pix(8, 0, 81);
        check("ovf_col7", ovf, 0);
        pix(9, 0, 91);
        check("ovf_col8", ovf, 1);
        for (int x = 0; x < 10; x++) pix(x, 1, 500 + x);
        idle(4);
        check("ovf_sticky", ovf, 1);
        @(negedge clk) begin dval = 1'b0; ovf_clr = 1'b1; end
        idle(1);
        check("ovf_cleared", ovf, 0);
        for (int x = 0; x < 8; x++) pix(x, 2, 30 + x);
        pix(8, 2, 99);
        ovf_clr = 1'b1;
        idle(1);
        check("ovf_set_wins", ovf, 1);
        idle(2);

        // reset mid odd row: in-flight block dropped, no output until an even row
        pattern = 2'b00; gmode = 2'b11;
        row4(0, 100, 200, 110, 210);
        pix(0, 1, 300); pix(1, 1, 400);
        @(posedge clk);
        #1;
        rst_b = 1'b0; dval = 1'b0;
        q.delete();
        stored_m = 0; pat_m = 2; mode_m = 0; bl_ok = 0;
        idle(2);
        check("ovf_in_reset", ovf, 0);
        @(negedge clk) rst_b = 1'b1;
        pix(2, 1, 310); pix(3, 1, 410);
        row4(3, 1, 2, 3, 4);
        idle(3);
        row4(2, 600, 700, 610, 710);
        row4(3, 800, 900, 810, 910);
        idle(6);
        check("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
